wb_sram_target: RTL

//  Wishbone classic-cycle responder backed by a byte-enabled scratch RAM.

---
 rtl/wb_sram_target_pkg.sv | 15 +
 rtl/wb_sram_target_ram.sv | 28 ++
 rtl/wb_sram_target.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_sram_target_pkg.sv
// Shared types and helpers for the Wishbone scratch-RAM target.
package wb_sram_target_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_sram_target_state_t;

  // Number of byte-address bits that select a lane within one data word.
  function automatic int lane_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/wb_sram_target_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module wb_sram_target_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] be_i,
  input  logic            we_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem [2**AW];

  // No reset here so the array maps onto block RAM; reads return the old word on a write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we_i && be_i[i]) begin
        mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/wb_sram_target.sv
// Wishbone classic-cycle responder with wait states, byte-lane writes and ERR on out-of-range.
module wb_sram_target
  import wb_sram_target_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int WAIT_STATES    = 0,
  parameter int ERR_ON_OOR     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_ADDR_WIDTH-1:0]   adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   dat_w_i,
  input  logic [WB_DATA_WIDTH/8-1:0] sel_i,
  input  logic                       we_i,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  output logic [WB_DATA_WIDTH-1:0]   dat_r_o,
  output logic                       ack_o,
  output logic                       err_o
);

  localparam int LB = lane_bits(WB_DATA_WIDTH);
  localparam int NB = WB_DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_sram_target_state_t state_q, state_d;
  logic [3:0]                count_q, count_d;
  logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [WB_DATA_WIDTH-1:0]  wdat_q, wdat_d;
  logic [NB-1:0]             sel_q, sel_d;
  logic                      we_q, we_d;
  logic                      oor_q, oor_d;

  logic [WB_ADDR_WIDTH-1:0]  reqWord;
  logic [MEM_ADDR_WIDTH-1:0] reqIdx;
  logic                      reqOor;
  logic [MEM_ADDR_WIDTH-1:0] ramAddr;
  logic                      ramWe;
  logic [WB_DATA_WIDTH-1:0]  ramRdata;

  // Word index drops the lane bits; anything left above the RAM depth is out of range.
  assign reqWord = adr_i >> LB;
  assign reqIdx  = reqWord[MEM_ADDR_WIDTH-1:0];
  assign reqOor  = (ERR_ON_OOR != 0) && (|(reqWord >> MEM_ADDR_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          idx_d  = reqIdx;
          wdat_d = dat_w_i;
          sel_d  = sel_i;
          we_d   = we_i;
          oor_d  = reqOor;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            count_d = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A master dropping CYC mid-wait abandons the access entirely.
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (count_q == 4'd0) begin
          state_d = RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read address follows the live bus in IDLE so the word is ready in RESP with zero wait states.
  assign ramAddr = (state_q == IDLE) ? reqIdx : idx_q;
  assign ramWe   = (state_q == RESP) && we_q && !oor_q;

  wb_sram_target_ram #(
    .AW(MEM_ADDR_WIDTH),
    .DW(WB_DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .addr_i (ramAddr),
    .wdata_i(wdat_q),
    .be_i   (sel_q),
    .we_i   (ramWe),
    .rdata_o(ramRdata)
  );

  assign ack_o   = (state_q == RESP) && !oor_q;
  assign err_o   = (state_q == RESP) && oor_q;
  assign dat_r_o = ((state_q == RESP) && !we_q && !oor_q) ? ramRdata : '0;

endmodule
